// File: rtl/gate_sequence_accumulator.sv
// Gate sequence accumulator: folds a stream of 2x2 complex gate matrices into
// a running product acc = gate x acc (starting from identity) by driving an
// external 2x2 complex matrix multiplier over a ready/available handshake.
// Operands are held in registers for the whole multiply so the multiplier
// never sees them change mid-computation.
module gate_sequence_accumulator #(
    parameter int WIDTH     = 37,
    parameter int FRAC_BITS = 35,
    parameter int COUNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] gate_mtx [0:1][0:1][0:1],
    input  logic                    gate_valid,
    input  logic                    gate_last,
    output logic                    gate_ready,
    output logic signed [WIDTH-1:0] mul_a [0:1][0:1][0:1],
    output logic signed [WIDTH-1:0] mul_b [0:1][0:1][0:1],
    output logic                    mul_ready,
    input  logic signed [WIDTH-1:0] mul_r [0:1][0:1][0:1],
    input  logic                    mul_available,
    output logic signed [WIDTH-1:0] result [0:1][0:1][0:1],
    output logic                    result_valid,
    input  logic                    result_ack,
    output logic [COUNT_W-1:0]      gate_count,
    output logic                    busy
);

    localparam logic signed [WIDTH-1:0] FIX_ONE = WIDTH'(1) << FRAC_BITS;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GATE,
        ISSUE,
        WAIT_DONE,
        DONE
    } state_t;

    state_t                  state_reg;
    logic signed [WIDTH-1:0] gate_reg [0:1][0:1][0:1];
    logic signed [WIDTH-1:0] acc_reg  [0:1][0:1][0:1];
    logic                    last_flag_reg;
    logic [COUNT_W-1:0]      count_reg;
    logic                    result_valid_reg;
    logic                    busy_reg;
    logic                    start_new;

    // A new sequence may only begin from IDLE or DONE; start is ignored mid-sequence.
    assign start_new = start && (state_reg == IDLE || state_reg == DONE);

    assign gate_ready   = (state_reg == WAIT_GATE);
    // The request simply mirrors availability while in ISSUE, so the handshake
    // edge is the first edge in ISSUE with the multiplier idle.
    assign mul_ready    = (state_reg == ISSUE) && mul_available;
    assign result_valid = result_valid_reg;
    assign gate_count   = count_reg;
    assign busy         = busy_reg;

    // Operand and result views are direct taps of the gate register and accumulator.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_row
            for (genvar gj = 0; gj < 2; gj++) begin : g_col
                for (genvar gk = 0; gk < 2; gk++) begin : g_part
                    assign mul_a[gi][gj][gk]  = gate_reg[gi][gj][gk];
                    assign mul_b[gi][gj][gk]  = acc_reg[gi][gj][gk];
                    assign result[gi][gj][gk] = acc_reg[gi][gj][gk];
                end
            end
        end
    endgenerate

    // Sequence controller: state, operand registers, accumulator and registered status.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            last_flag_reg    <= 1'b0;
            count_reg        <= '0;
            result_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
            for (int r = 0; r < 2; r++) begin
                for (int c = 0; c < 2; c++) begin
                    for (int p = 0; p < 2; p++) begin
                        gate_reg[r][c][p] <= '0;
                        acc_reg[r][c][p]  <= '0;
                    end
                end
            end
        end else if (start_new) begin
            // Fresh sequence: accumulator becomes identity (real diagonal = 1.0).
            for (int r = 0; r < 2; r++) begin
                for (int c = 0; c < 2; c++) begin
                    for (int p = 0; p < 2; p++) begin
                        acc_reg[r][c][p] <= (r == c && p == 0) ? FIX_ONE : '0;
                    end
                end
            end
            count_reg        <= '0;
            result_valid_reg <= 1'b0;
            busy_reg         <= 1'b1;
            state_reg        <= WAIT_GATE;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg <= IDLE;
                end
                WAIT_GATE: begin
                    if (gate_valid) begin
                        gate_reg      <= gate_mtx;
                        last_flag_reg <= gate_last;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mul_available) begin
                        state_reg <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    // Availability returning after the handshake marks a valid result.
                    if (mul_available) begin
                        acc_reg <= mul_r;
                        if (count_reg != {COUNT_W{1'b1}}) begin
                            count_reg <= count_reg + 1'b1;
                        end
                        if (last_flag_reg) begin
                            result_valid_reg <= 1'b1;
                            busy_reg         <= 1'b0;
                            state_reg        <= DONE;
                        end else begin
                            state_reg <= WAIT_GATE;
                        end
                    end
                end
                DONE: begin
                    if (result_ack) begin
                        result_valid_reg <= 1'b0;
                        state_reg        <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sequence_accumulator.sv
// Bench for gate_sequence_accumulator: a stub multiplier (8-cycle busy window,
// optional extra stall) plus a reference model in which every gate is a
// monomial unitary (one entry of 1, i, -1 or -i per row), so products are
// tracked exactly as a permutation plus per-row phases.
`timescale 1ns/1ps
module tb_gate_sequence_accumulator;

    localparam int WIDTH = 37;
    localparam int FRAC  = 35;
    localparam int CW    = 8;
    localparam logic signed [WIDTH-1:0] ONE = 37'sd34359738368;

    typedef logic signed [WIDTH-1:0] mtx_t [0:1][0:1][0:1];

    // Monomial matrix: row r has its single nonzero in column p_r with value i^ph_r.
    typedef struct packed {
        logic [1:0] ph1;
        logic [1:0] ph0;
        logic       p1;
        logic       p0;
    } mono_t;

    typedef struct packed {
        logic [2:0]      n;
        mono_t [3:0]     g;
        mono_t           exp;
        logic [3:0]      gap;
        logic            stall;
        logic            spur;
        logic            ack_hold;
        logic            do_ack;
        logic            chk_exp;
    } vec_t;

    localparam mono_t M_I = '{ph1: 2'd0, ph0: 2'd0, p1: 1'b1, p0: 1'b0};
    localparam mono_t M_X = '{ph1: 2'd0, ph0: 2'd0, p1: 1'b0, p0: 1'b1};
    localparam mono_t M_S = '{ph1: 2'd1, ph0: 2'd0, p1: 1'b1, p0: 1'b0};
    localparam mono_t M_Z = '{ph1: 2'd2, ph0: 2'd0, p1: 1'b1, p0: 1'b0};
    localparam mono_t M_Y = '{ph1: 2'd1, ph0: 2'd3, p1: 1'b0, p0: 1'b1};
    // S*X = [[0,1],[i,0]]
    localparam mono_t M_SX = '{ph1: 2'd1, ph0: 2'd0, p1: 1'b0, p0: 1'b1};
    // Z*X*Y = [[i,0],[0,i]]
    localparam mono_t M_ZXY = '{ph1: 2'd1, ph0: 2'd1, p1: 1'b1, p0: 1'b0};

    logic clk = 1'b0;
    logic reset, start, gate_valid, gate_last, gate_ready, mul_ready, mul_available;
    logic result_valid, result_ack, busy;
    logic [CW-1:0] gate_count;
    mtx_t gate_in, mul_a, mul_b, mul_r, result;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int stab_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gate_sequence_accumulator #(.WIDTH(WIDTH), .FRAC_BITS(FRAC), .COUNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .gate_mtx(gate_in), .gate_valid(gate_valid), .gate_last(gate_last),
        .gate_ready(gate_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_ready(mul_ready),
        .mul_r(mul_r), .mul_available(mul_available),
        .result(result), .result_valid(result_valid), .result_ack(result_ack),
        .gate_count(gate_count), .busy(busy)
    );

    // ---------------- stub multiplier ----------------
    logic [3:0] stub_cnt;
    logic       stub_hold;
    mtx_t       stub_r, snap_a, snap_b;

    assign mul_available = (stub_cnt == 4'd0) && !stub_hold;
    assign mul_r = stub_r;

    function automatic logic signed [WIDTH-1:0] cmul(mtx_t a, mtx_t b, int r, int c, int part);
        logic signed [79:0] acc, ar, ai, br, bi;
        acc = '0;
        for (int k = 0; k < 2; k++) begin
            ar = a[r][k][0]; ai = a[r][k][1];
            br = b[k][c][0]; bi = b[k][c][1];
            if (part == 0) acc = acc + ar * br - ai * bi;
            else           acc = acc + ar * bi + ai * br;
        end
        acc = acc >>> FRAC;
        return acc[WIDTH-1:0];
    endfunction

    function automatic bit same(mtx_t x, mtx_t y);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                for (int p = 0; p < 2; p++)
                    if (x[r][c][p] !== y[r][c][p]) return 1'b0;
        return 1'b1;
    endfunction

    // Stub multiplier: latch product at the handshake, stay unavailable 8 cycles,
    // and count operand changes seen while it is busy.
    always @(posedge clk) begin
        if (reset) begin
            stub_cnt <= 4'd0;
        end else if (mul_ready) begin
            stub_cnt  <= 4'd8;
            pulse_cnt <= pulse_cnt + 1;
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 2; c++)
                    for (int p = 0; p < 2; p++)
                        stub_r[r][c][p] <= cmul(mul_a, mul_b, r, c, p);
            snap_a <= mul_a;
            snap_b <= mul_b;
        end else if (stub_cnt != 4'd0) begin
            stub_cnt <= stub_cnt - 4'd1;
            if (!same(mul_a, snap_a) || !same(mul_b, snap_b)) stab_err <= stab_err + 1;
        end
    end

    // ---------------- reference model ----------------
    function automatic mono_t mono_mul(mono_t g, mono_t a);
        mono_t m;
        m.p0  = g.p0 ? a.p1 : a.p0;
        m.ph0 = g.ph0 + (g.p0 ? a.ph1 : a.ph0);
        m.p1  = g.p1 ? a.p1 : a.p0;
        m.ph1 = g.ph1 + (g.p1 ? a.ph1 : a.ph0);
        return m;
    endfunction

    // Fixed-point value of element [r][c] part (0=re,1=im) of a monomial matrix.
    function automatic logic signed [WIDTH-1:0] fx(mono_t m, int r, int c, int part);
        logic       p;
        logic [1:0] ph;
        p  = (r == 1) ? m.p1 : m.p0;
        ph = (r == 1) ? m.ph1 : m.ph0;
        if (c != int'(p)) return '0;
        if (part != int'(ph[0])) return '0;
        return ph[1] ? -ONE : ONE;
    endfunction

    function automatic mono_t rand_mono();
        mono_t m;
        m.p0  = 1'($urandom_range(0, 1));
        m.p1  = ~m.p0;
        m.ph0 = 2'($urandom_range(0, 3));
        m.ph1 = 2'($urandom_range(0, 3));
        return m;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_mtx(input string name, input mtx_t x, input mono_t m);
        bit bad;
        bad = 1'b0;
        tests++;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                for (int p = 0; p < 2; p++)
                    if (!bad && x[r][c][p] !== fx(m, r, c, p)) begin
                        bad = 1'b1;
                        $display("FAIL %s: [%0d][%0d][%0d] got %0d expected %0d",
                                 name, r, c, p, x[r][c][p], fx(m, r, c, p));
                    end
        if (bad) fails++;
    endtask

    task automatic chk_zero(input string name, input mtx_t x);
        mtx_t z;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                for (int p = 0; p < 2; p++)
                    z[r][c][p] = '0;
        tests++;
        if (!same(x, z)) begin
            fails++;
            $display("FAIL %s: got nonzero matrix expected all zero", name);
        end
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, "_gate_ready"}, gate_ready, 0);
        chk({name, "_mul_ready"}, mul_ready, 0);
        chk({name, "_result_valid"}, result_valid, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_gate_count"}, gate_count, 0);
        chk_zero({name, "_mul_a"}, mul_a);
        chk_zero({name, "_mul_b"}, mul_b);
        chk_zero({name, "_result"}, result);
    endtask

    task automatic drive_gate(input mono_t m);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                for (int p = 0; p < 2; p++)
                    gate_in[r][c][p] = fx(m, r, c, p);
    endtask

    task automatic drive_junk();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                for (int p = 0; p < 2; p++)
                    gate_in[r][c][p] = WIDTH'($urandom);
    endtask

    // Run one full sequence, checking latency, operands, result and count.
    task automatic run_seq(input vec_t v, input string name);
        mono_t model;
        int t_acc, t_rdy, extra, k, p0;
        model = M_I;
        p0 = pulse_cnt;
        t_acc = 0;
        extra = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < int'(v.n); i++) begin
            k = 0;
            while (!gate_ready && k < 60) begin @(negedge clk); k++; end
            if (!gate_ready) begin
                chk({name, "_ready_timeout"}, 0, 1);
                return;
            end
            t_rdy = cyc;
            if (i > 0) chk({name, "_gate_interval"}, t_rdy - t_acc, 10 + extra);
            for (int j = 0; j < int'(v.gap); j++) begin
                chk({name, "_gap_ready"}, gate_ready, 1);
                chk_mtx({name, "_gap_mul_b"}, mul_b, model);
                @(negedge clk);
            end
            extra = (v.stall && i == 0) ? 3 : 0;
            if (extra != 0) stub_hold = 1'b1;
            drive_gate(v.g[i]);
            gate_valid = 1'b1;
            gate_last  = (i == int'(v.n) - 1);
            @(negedge clk);
            t_acc = cyc;
            gate_valid = 1'b0;
            gate_last  = 1'b0;
            drive_junk();
            model = mono_mul(v.g[i], model);
            if (extra != 0) begin
                repeat (3) begin
                    chk({name, "_stall_mul_ready"}, mul_ready, 0);
                    @(negedge clk);
                end
                stub_hold = 1'b0;
            end else begin
                // Junk gate and (optionally) start while the multiply is in flight.
                gate_valid = 1'b1;
                gate_last  = 1'b1;
                start = v.spur;
                @(negedge clk);
                gate_valid = 1'b0;
                gate_last  = 1'b0;
                start = 1'b0;
            end
        end
        k = 0;
        while (!result_valid && k < 60) begin @(negedge clk); k++; end
        chk({name, "_result_valid"}, result_valid, 1);
        chk({name, "_latency"}, cyc - t_acc, 10 + extra);
        chk_mtx({name, "_result_model"}, result, model);
        if (v.chk_exp) chk_mtx({name, "_result_table"}, result, v.exp);
        chk({name, "_gate_count"}, gate_count, v.n);
        chk({name, "_mul_pulses"}, pulse_cnt - p0, v.n);
        chk({name, "_operand_stable"}, stab_err, 0);
        chk({name, "_busy_done"}, busy, 0);
        if (v.ack_hold) begin
            repeat (4) begin
                @(negedge clk);
                chk({name, "_hold_valid"}, result_valid, 1);
                chk_mtx({name, "_hold_result"}, result, model);
            end
        end
        if (v.do_ack) begin
            result_ack = 1'b1;
            @(negedge clk);
            result_ack = 1'b0;
            chk({name, "_ack_valid"}, result_valid, 0);
            chk({name, "_ack_idle_ready"}, gate_ready, 0);
        end
    endtask

    function automatic vec_t mk(int n, mono_t g0, mono_t g1, mono_t g2, mono_t g3, mono_t e,
                                int gap, bit stall, bit spur, bit hold, bit ack, bit ce);
        vec_t v;
        v.n = 3'(n);
        v.g[0] = g0; v.g[1] = g1; v.g[2] = g2; v.g[3] = g3;
        v.exp = e;
        v.gap = 4'(gap);
        v.stall = stall; v.spur = spur; v.ack_hold = hold; v.do_ack = ack; v.chk_exp = ce;
        return v;
    endfunction

    vec_t tbl [6];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        tbl[0] = mk(1, M_X, M_I, M_I, M_I, M_X,   0, 0, 0, 0, 1, 1);
        tbl[1] = mk(2, M_X, M_X, M_I, M_I, M_I,   0, 0, 0, 0, 1, 1);
        tbl[2] = mk(2, M_S, M_S, M_I, M_I, M_Z,   0, 0, 0, 0, 1, 1);
        tbl[3] = mk(2, M_X, M_X, M_I, M_I, M_I,   5, 0, 0, 0, 1, 1);
        tbl[4] = mk(2, M_X, M_S, M_I, M_I, M_SX,  0, 1, 1, 1, 1, 1);
        tbl[5] = mk(3, M_Y, M_X, M_Z, M_I, M_ZXY, 0, 0, 0, 0, 1, 1);

        reset = 1'b1; start = 1'b0; gate_valid = 1'b0; gate_last = 1'b0;
        result_ack = 1'b0; stub_hold = 1'b0;
        drive_junk();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_state("reset");

        for (int i = 0; i < 6; i++) begin
            run_seq(tbl[i], $sformatf("tbl%0d", i));
            if (i == 0) begin
                // X was run alone and acknowledged; the accumulator still holds X.
                chk("x_lit_01_re", result[0][1][0], ONE);
                chk("x_lit_10_re", result[1][0][0], ONE);
                chk("x_lit_00_re", result[0][0][0], 0);
            end
        end

        // Reset while the multiplier is busy.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        drive_gate(M_X); gate_valid = 1'b1; gate_last = 1'b0;
        @(negedge clk); gate_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_state("mid_reset");
        reset = 1'b0;
        run_seq(mk(2, M_X, M_X, M_I, M_I, M_I, 0, 0, 0, 1, 0, 1), "post_reset");

        // In DONE: start together with ack begins a new sequence.
        start = 1'b1; result_ack = 1'b1;
        @(negedge clk);
        start = 1'b0; result_ack = 1'b0;
        chk("startack_valid", result_valid, 0);
        chk("startack_ready", gate_ready, 1);
        chk("startack_busy", busy, 1);
        chk("startack_count", gate_count, 0);
        chk_mtx("startack_identity", result, M_I);
        run_seq(mk(2, M_X, M_X, M_I, M_I, M_I, 0, 0, 0, 0, 1, 1), "startack_seq");

        // Randomized sequences against the monomial model.
        for (int i = 0; i < 8; i++) begin
            v = mk($urandom_range(1, 4), rand_mono(), rand_mono(), rand_mono(), rand_mono(),
                   M_I, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 0, 1, 0);
            run_seq(v, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
